// File: rtl/lcd_timing_driver_pkg.sv
// Shared raster geometry and the screen_point type, used by the panel timing
// driver and by the pixel consumer so that both agree on the frame layout.
package lcd_timing_driver_pkg;

  localparam int SCREEN_WIDTH      = 480;
  localparam int SCREEN_HEIGHT     = 272;
  localparam int H_FRONT_PORCH     = 2;
  localparam int H_SYNC_WIDTH      = 41;
  localparam int H_BACK_PORCH      = 2;
  localparam int V_FRONT_PORCH     = 2;
  localparam int V_SYNC_WIDTH      = 10;
  localparam int V_BACK_PORCH      = 2;
  localparam int HORIZONTAL_PERIOD = 525;
  localparam int VERTICAL_PERIOD   = 286;

  localparam int POINT_X_W = 10;
  localparam int POINT_Y_W = 9;

  typedef struct packed {
    logic [POINT_X_W-1:0] x;
    logic [POINT_Y_W-1:0] y;
  } point_t;

endpackage

// File: rtl/timing_delay_line.sv
// Fixed-depth shift register with asynchronous active-low clear; carries the
// raw raster strobes alongside the controller's colour latency.
module timing_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic [WIDTH-1:0] q;
    if (gi == 0) begin : g_first
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) q <= '0;
        else          q <= din;
      end
    end else begin : g_next
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) q <= '0;
        else          q <= g_stage[gi-1].q;
      end
    end
  end

  assign dout = g_stage[DEPTH-1].q;

endmodule

// File: rtl/lcd_timing_driver.sv
// Raster timing generator for the RGB-parallel panel: publishes the current
// raster point and drives sync/DE/colour pins aligned PIXEL_LATENCY+1 later.
module lcd_timing_driver
  import lcd_timing_driver_pkg::*;
#(
  parameter int H_ACTIVE        = SCREEN_WIDTH,
  parameter int H_FRONT         = H_FRONT_PORCH,
  parameter int H_SYNC          = H_SYNC_WIDTH,
  parameter int H_BACK          = H_BACK_PORCH,
  parameter int V_ACTIVE        = SCREEN_HEIGHT,
  parameter int V_FRONT         = V_FRONT_PORCH,
  parameter int V_SYNC          = V_SYNC_WIDTH,
  parameter int V_BACK          = V_BACK_PORCH,
  parameter int PIXEL_LATENCY   = 2,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       clock,
  input  logic       reset_n,
  output point_t     screen_point,
  output logic       frame_start,
  input  logic [2:0] pixel_r,
  input  logic [1:0] pixel_g,
  input  logic [2:0] pixel_b,
  output logic       lcd_hsync,
  output logic       lcd_vsync,
  output logic       lcd_de,
  output logic [2:0] lcd_r,
  output logic [1:0] lcd_g,
  output logic [2:0] lcd_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [POINT_X_W-1:0] H_LAST     = POINT_X_W'(H_TOTAL - 1);
  localparam logic [POINT_X_W-1:0] H_ACT_END  = POINT_X_W'(H_ACTIVE);
  localparam logic [POINT_X_W-1:0] HS_START   = POINT_X_W'(H_ACTIVE + H_FRONT);
  localparam logic [POINT_X_W-1:0] HS_END     = POINT_X_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [POINT_Y_W-1:0] V_LAST     = POINT_Y_W'(V_TOTAL - 1);
  localparam logic [POINT_Y_W-1:0] V_ACT_END  = POINT_Y_W'(V_ACTIVE);
  localparam logic [POINT_Y_W-1:0] VS_START   = POINT_Y_W'(V_ACTIVE + V_FRONT);
  localparam logic [POINT_Y_W-1:0] VS_END     = POINT_Y_W'(V_ACTIVE + V_FRONT + V_SYNC);

  localparam logic SYNC_OFF = SYNC_ACTIVE_LOW;
  localparam logic SYNC_ON  = ~SYNC_ACTIVE_LOW;

  logic [POINT_X_W-1:0] h_count;
  logic [POINT_Y_W-1:0] v_count;
  logic                 de_raw;
  logic                 hs_raw;
  logic                 vs_raw;
  logic [2:0]           strobe_dly;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_count <= '0;
      v_count <= '0;
    end else if (h_count == H_LAST) begin
      h_count <= '0;
      v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
    end else begin
      h_count <= h_count + 1'b1;
    end
  end

  assign screen_point = '{x: h_count, y: v_count};
  assign frame_start  = (h_count == '0) && (v_count == '0);

  assign de_raw = (h_count < H_ACT_END) && (v_count < V_ACT_END);
  assign hs_raw = (h_count >= HS_START) && (h_count < HS_END);
  assign vs_raw = (v_count >= VS_START) && (v_count < VS_END);

  // Strobes wait out the controller's colour latency before the output register.
  timing_delay_line #(
    .DEPTH (PIXEL_LATENCY),
    .WIDTH (3)
  ) u_strobe_delay (
    .clock   (clock),
    .reset_n (reset_n),
    .din     ({de_raw, hs_raw, vs_raw}),
    .dout    (strobe_dly)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lcd_de    <= 1'b0;
      lcd_hsync <= SYNC_OFF;
      lcd_vsync <= SYNC_OFF;
      lcd_r     <= '0;
      lcd_g     <= '0;
      lcd_b     <= '0;
    end else begin
      lcd_de    <= strobe_dly[2];
      lcd_hsync <= strobe_dly[1] ? SYNC_ON : SYNC_OFF;
      lcd_vsync <= strobe_dly[0] ? SYNC_ON : SYNC_OFF;
      lcd_r     <= strobe_dly[2] ? pixel_r : '0;
      lcd_g     <= strobe_dly[2] ? pixel_g : '0;
      lcd_b     <= strobe_dly[2] ? pixel_b : '0;
    end
  end

endmodule

// File: tb/tb_lcd_timing_driver.sv
// Directed bench: three drivers on a shrunken raster (latency 2, 1, 4) fed by
// a latency-matched controller model, checked cycle by cycle against a counter.
module tb_lcd_timing_driver;
  import lcd_timing_driver_pkg::*;

  localparam int HA = 8, HF = 2, HSW = 3, HB = 2;
  localparam int VA = 4, VF = 1, VSW = 2, VB = 1;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FRAME = HT * VT;
  localparam int LAT[3] = '{2, 1, 4};
  localparam bit AL[3]  = '{1'b1, 1'b1, 1'b0};

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [18:0] pt_obs  [3];
  logic        fs_obs  [3];
  logic [10:0] out_obs [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] color(int x, int y);
    return 8'(x * 29 + y * 7 + 3);
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    point_t      pt;
    logic        fs;
    logic [2:0]  pr, pb, lr, lb;
    logic [1:0]  pg, lg;
    logic        hs, vs, de;
    logic [7:0]  pipe [4];

    lcd_timing_driver #(
      .H_ACTIVE (HA), .H_FRONT (HF), .H_SYNC (HSW), .H_BACK (HB),
      .V_ACTIVE (VA), .V_FRONT (VF), .V_SYNC (VSW), .V_BACK (VB),
      .PIXEL_LATENCY (LAT[gi]), .SYNC_ACTIVE_LOW (AL[gi])
    ) dut (
      .clock        (clk),
      .reset_n      (rst_n),
      .screen_point (pt),
      .frame_start  (fs),
      .pixel_r      (pr),
      .pixel_g      (pg),
      .pixel_b      (pb),
      .lcd_hsync    (hs),
      .lcd_vsync    (vs),
      .lcd_de       (de),
      .lcd_r        (lr),
      .lcd_g        (lg),
      .lcd_b        (lb)
    );

    // Controller model: colour of the point, 8'hFF in blanking, LAT clocks late.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < 4; k++) pipe[k] <= 8'h00;
      end else begin
        pipe[0] <= (int'(pt.x) < HA && int'(pt.y) < VA) ? color(int'(pt.x), int'(pt.y)) : 8'hFF;
        for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
      end
    end
    assign {pr, pg, pb} = pipe[LAT[gi]-1];

    assign pt_obs[gi]  = pt;
    assign fs_obs[gi]  = fs;
    assign out_obs[gi] = {hs, vs, de, lr, lg, lb};
  end

  task automatic chk(string tag, int idx, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s dut=%0d observed=%0h expected=%0h t=%0t", tag, idx, obs, exp, $time);
      $error("%s dut=%0d observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  function automatic logic [10:0] exp_out(int lat, bit al, int c);
    int s, x, y;
    logic de, hs, vs;
    logic [7:0] rgb;
    if (c < lat + 1) return {al, al, 1'b0, 8'h00};
    s  = (c - lat - 1) % FRAME;
    x  = s % HT;
    y  = s / HT;
    de = (x < HA) && (y < VA);
    hs = (x >= HA + HF) && (x < HA + HF + HSW);
    vs = (y >= VA + VF) && (y < VA + VF + VSW);
    rgb = de ? color(x, y) : 8'h00;
    return {hs ? ~al : al, vs ? ~al : al, de, rgb};
  endfunction

  task automatic check_cycle(int c);
    int s;
    s = c % FRAME;
    for (int i = 0; i < 3; i++) begin
      chk("point", i, 32'(pt_obs[i]), 32'({10'(s % HT), 9'(s / HT)}));
      chk("frame_start", i, 32'(fs_obs[i]), 32'(s == 0));
      chk("lcd_pins", i, 32'(out_obs[i]), 32'(exp_out(LAT[i], AL[i], c)));
    end
  endtask

  task automatic check_reset_state(string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_point"}, i, 32'(pt_obs[i]), 32'h0);
      chk({tag, "_frame_start"}, i, 32'(fs_obs[i]), 32'h1);
      chk({tag, "_pins"}, i, 32'(out_obs[i]), 32'({AL[i], AL[i], 1'b0, 8'h00}));
    end
  endtask

  initial begin
    int de_cnt, hs_cnt, vs_cnt;
    checks = 0;
    failures = 0;
    de_cnt = 0;
    hs_cnt = 0;
    vs_cnt = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_state("in_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Two frames plus part of a third, every cycle checked.
    for (int c = 0; c <= 2 * FRAME + 2 * HT + 5; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      check_cycle(c);
      if (c >= 3 && c < 3 + FRAME) begin
        if (out_obs[0][8]) de_cnt++;
        if (!out_obs[0][10]) hs_cnt++;
        if (!out_obs[0][9]) vs_cnt++;
      end
    end
    $display("phase frames: checks=%0d failures=%0d", checks, failures);
    chk("de_per_frame", 0, 32'(de_cnt), 32'(HA * VA));
    chk("hsync_per_frame", 0, 32'(hs_cnt), 32'(HSW * VT));
    chk("vsync_per_frame", 0, 32'(vs_cnt), 32'(VSW * HT));

    // Mid-frame reset while DE is high: outputs clear at once.
    rst_n = 1'b0;
    #1;
    check_reset_state("async_reset");
    repeat (3) @(negedge clk);
    #1;
    check_reset_state("held_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < FRAME + 30; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      check_cycle(c);
    end
    $display("phase restart: checks=%0d failures=%0d", checks, failures);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
